ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single-port 256x8 synchronous RAM between three requesters: instruction fetch (IP register path), data load/store (control unit), and a debug/loader port (BASYS3 switches/UART). Sits between the CPU core and the RAM instance, driving the RAM `Csel`/read/address/data pins. Uses fixed priority with age-based anti-starvation, a registered grant, and one-cycle-latency read return.

## Interface
- `AW`, 8, address width (256 locations)
- `DW`, 8, data width
- `STARVE`, 4, consecutive denied request cycles before a requester is promoted to top priority (1..15)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: **asynchronous, active-low reset**
- `f_req` in 1: fetch request (read only)
- `f_addr` in AW: fetch address (`ipnext`)
- `d_req`, `d_we` in 1 each: data request, write enable
- `d_addr` in AW, `d_wdata` in DW: data address and write data
- `x_req`, `x_we` in 1 each: debug request, write enable
- `x_addr` in AW, `x_wdata` in DW: debug address and write data
- `gnt` out 3: one-hot grant `{x,d,f}`, registered
- `rvalid` out 3: one-hot read-data-valid `{x,d,f}`
- `rdata` out DW: shared read-data bus
- `ram_csel` out 1: RAM chip select, active-high
- `ram_read` out 1: 1 = read, 0 = write
- `ram_addr` out AW, `ram_wdata` out DW: RAM address and write data
- `ram_rdata` in DW: RAM read data, valid one cycle after a read select

## Operation
- **Requester rule:** hold `req`/`we`/`addr`/`wdata` stable until `gnt` is seen high. In the `gnt` cycle a requester may drop `req` or present a new request.
- **Arbiter rule:** ignores a requester's `req` in the cycle that requester's `gnt` is high. This prevents double issue, so each requester gets at most one grant per 2 cycles; aggregate throughput is one access per cycle.
- **Eligibility:** requester i is eligible at edge T if `req_i` is high and `gnt_i` is low.
- **Priority:** starved eligible requesters first, then D > F > X. Ties among starved requesters also resolve D > F > X.
- **Age counters:** one 4-bit counter per requester.
  - Eligible but not granted: increment, saturating at 15.
  - Granted, or `req` low: clear.
  - Starved means counter >= `STARVE`.
- **On grant:** register `gnt` one-hot and drive `ram_csel`=1, `ram_addr`, `ram_read`=!we, and `ram_wdata` (the requester's wdata, or 0 on a read) from the winner, all in the same cycle.
- **Reads:** a 1-entry tag register records the winner of the read. The next cycle, `rvalid[tag]`=1 and `rdata`=`ram_rdata`.
- **Writes:** complete in the `gnt` cycle and never produce `rvalid`. Fetch is always a read.
- **Idle:** no eligible requester → `ram_csel`=0, `gnt`=0, `ram_read`=1, `ram_addr` and `ram_wdata` hold their previous values.
- **Overlap:** `rvalid` for access N and `gnt` for access N+1 may coincide.
- **`rdata` when no `rvalid`:** holds its last value.

## Timing
- **Reset values:** `gnt`=0, `rvalid`=0, `rdata`=0, `ram_csel`=0, `ram_read`=1, `ram_addr`=0, `ram_wdata`=0, age counters=0, tag=none.
- **Read latency:** `req` sampled at edge T → `gnt`/`ram_csel` high during cycle T+1 → `rvalid`/`rdata` during cycle T+2.
- **Write latency:** RAM is written at edge T+2 (end of the `gnt` cycle).
- **Worst-case wait for X under continuous D and F load:** `STARVE`+2 cycles.
- **Reset mid-access:** an outstanding read's `rvalid` is dropped and never issued after reset release.
- **Reset release:** the first grant is possible on the second rising edge after `rst_n` rises.

## Structure
- **Package `cpu_pkg`:** `AW`/`DW` defaults, requester index constants `REQ_F=0`, `REQ_D=1`, `REQ_X=2`, and a `req_t` struct {req, we, addr, wdata}.
- **Sub-module `prio_pick`:** combinational. Inputs: eligible mask and starved mask. Output: one-hot winner. It is unit-tested separately.
- **Top:** registers, age counters, tag, output muxing; 150–250 lines total.

## Test plan
1. Reset, then `f_req`=1 at `f_addr`=0x10 with RAM[0x10]=0xA5 → `gnt`=001 in cycle 2, `rvalid`=001 and `rdata`=0xA5 in cycle 3, `ram_read`=1.
2. Simultaneous `d_req`(write 0x3C to 0x80) and `f_req`(read 0x00) → D granted first with `ram_read`=0 and `ram_wdata`=0x3C, F granted the next cycle; no `rvalid` for D.
3. D and F request continuously, X requests 0x55 → X granted within `STARVE`+2 = 6 cycles; its counter clears after the grant.
4. Back-to-back reads F@0x01 then D@0x02 → `rvalid`=001 coincides with `gnt`=010; next cycle `rvalid`=010 with correct `rdata`.
5. `rst_n` pulsed low in the cycle after a read grant → `rvalid` never asserts; all outputs at reset values; a fresh request completes normally.
6. X write 0x77 to 0x40, then D read of 0x40 → D receives 0x77.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory subsystem.
// - DEF_AW / DEF_DW: default RAM address and data widths (256 x 8).
// - REQ_F / REQ_D / REQ_X: bit positions of the fetch, data and debug
//   requesters in every {x,d,f} vector.
// - req_t: one requester's request bundle at default widths.
package cpu_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 8;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned REQ_F = 0;
  localparam int unsigned REQ_D = 1;
  localparam int unsigned REQ_X = 2;

  // Saturation value of the 4-bit age counters.
  localparam logic [3:0] AGE_MAX = 4'd15;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection for the RAM arbiter.
// Ports:
//   elig    - requesters that may be granted this edge, {x,d,f}
//   starved - requesters whose age counter has reached the starvation limit
//   win     - one-hot winner, all zero when nothing is eligible
// Starved eligible requesters take precedence over everything else; within
// the chosen group the order is D > F > X.
module prio_pick
  import cpu_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  input  logic [NREQ-1:0] starved,
  output logic [NREQ-1:0] win
);

  logic [NREQ-1:0] hot;
  logic [NREQ-1:0] cand;

  assign hot  = elig & starved;
  assign cand = (|hot) ? hot : elig;

  always_comb begin
    win = '0;
    if (cand[REQ_D]) begin
      win[REQ_D] = 1'b1;
    end else if (cand[REQ_F]) begin
      win[REQ_F] = 1'b1;
    end else if (cand[REQ_X]) begin
      win[REQ_X] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch,
// data load/store and the debug/loader port.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   f_req, f_addr              - fetch request (always a read)
//   d_req, d_we, d_addr, d_wdata - data port request
//   x_req, x_we, x_addr, x_wdata - debug port request
//   gnt                        - registered one-hot grant {x,d,f}
//   rvalid, rdata              - one-hot read-data valid and shared read data
//   ram_csel, ram_read, ram_addr, ram_wdata - RAM control (registered)
//   ram_rdata                  - RAM read data, valid the cycle after a read select
// A request sampled at edge T is granted during the following cycle; read data
// returns one cycle later, possibly overlapping the next grant.
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned STARVE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_req,
  input  logic [AW-1:0]   f_addr,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic            x_req,
  input  logic            x_we,
  input  logic [AW-1:0]   x_addr,
  input  logic [DW-1:0]   x_wdata,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rvalid,
  output logic [DW-1:0]   rdata,
  output logic            ram_csel,
  output logic            ram_read,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  // State
  logic            run_q;
  logic [NREQ-1:0] gnt_q,      gnt_d;
  logic            csel_q,     csel_d;
  logic            read_q,     read_d;
  logic [AW-1:0]   addr_q,     addr_d;
  logic [DW-1:0]   wdata_q,    wdata_d;
  logic [NREQ-1:0] tag_q,      tag_d;
  logic [DW-1:0]   rdata_q;
  logic [3:0]      age_q [NREQ];
  logic [3:0]      age_d [NREQ];

  // Request vectors
  logic [NREQ-1:0] req_v;
  logic [NREQ-1:0] we_v;
  logic [AW-1:0]   addr_v  [NREQ];
  logic [DW-1:0]   wdata_v [NREQ];

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] starved;
  logic [NREQ-1:0] win;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;

  assign req_v = {x_req, d_req, f_req};
  assign we_v  = {x_we, d_we, 1'b0};

  assign addr_v[REQ_F]  = f_addr;
  assign addr_v[REQ_D]  = d_addr;
  assign addr_v[REQ_X]  = x_addr;
  assign wdata_v[REQ_F] = '0;
  assign wdata_v[REQ_D] = d_wdata;
  assign wdata_v[REQ_X] = x_wdata;

  // A requester holding its grant is ignored for one edge so the same
  // request is not issued twice. run_q blocks arbitration on the first edge
  // after reset release.
  assign elig = run_q ? (req_v & ~gnt_q) : '0;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      starved[i] = (age_q[i] >= 4'(STARVE));
    end
  end

  prio_pick u_prio_pick (
    .elig    (elig),
    .starved (starved),
    .win     (win)
  );

  // Winner's request fields
  always_comb begin
    win_we    = 1'b0;
    win_addr  = addr_q;
    win_wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win[i]) begin
        win_we    = we_v[i];
        win_addr  = addr_v[i];
        win_wdata = wdata_v[i];
      end
    end
  end

  // Next-state for the RAM-facing registers and the read tag
  always_comb begin
    gnt_d   = win;
    csel_d  = |win;
    read_d  = 1'b1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (|win) begin
      read_d  = ~win_we;
      addr_d  = win_addr;
      wdata_d = win_we ? win_wdata : '0;
    end
    // Remember who owns the read that the RAM samples at the end of this cycle.
    tag_d = (csel_q && read_q) ? gnt_q : '0;
  end

  // Age counters: count edges spent eligible but losing, clear otherwise.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!elig[i] || win[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 4'd1;
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      gnt_q   <= '0;
      csel_q  <= 1'b0;
      read_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        age_q[i] <= '0;
      end
    end else begin
      run_q   <= 1'b1;
      gnt_q   <= gnt_d;
      csel_q  <= csel_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      for (int i = 0; i < int'(NREQ); i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  // Read data passes straight through while valid and is held otherwise.
  assign rdata = (|tag_q) ? ram_rdata : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (|tag_q) begin
      rdata_q <= ram_rdata;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = tag_q;
  assign ram_csel  = csel_q;
  assign ram_read  = read_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x8 synchronous RAM.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       f_req, d_req, d_we, x_req, x_we;
  logic [7:0] f_addr, d_addr, d_wdata, x_addr, x_wdata;
  logic [2:0] gnt, rvalid;
  logic [7:0] rdata;
  logic       ram_csel, ram_read;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;

  logic [7:0] mem [256];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  ram_arbiter #(
    .AW     (8),
    .DW     (8),
    .STARVE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .x_req     (x_req),
    .x_we      (x_we),
    .x_addr    (x_addr),
    .x_wdata   (x_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_csel  (ram_csel),
    .ram_read  (ram_read),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM
  always @(posedge clk) begin
    if (ram_csel) begin
      if (ram_read) ram_rdata <= mem[ram_addr];
      else          mem[ram_addr] = ram_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   32'(gnt),       32'h0);
    check({tag, "_rvld"},  32'(rvalid),    32'h0);
    check({tag, "_rdata"}, 32'(rdata),     32'h0);
    check({tag, "_csel"},  32'(ram_csel),  32'h0);
    check({tag, "_read"},  32'(ram_read),  32'h1);
    check({tag, "_addr"},  32'(ram_addr),  32'h0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'h0);
  endtask

  initial begin
    int  waited;
    bit  got;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h11;
    mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h33;
    mem[8'h10] = 8'hA5;
    mem[8'h55] = 8'h9C;

    rst_n = 1'b0;
    f_req = 0; d_req = 0; d_we = 0; x_req = 0; x_we = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; x_addr = 0; x_wdata = 0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // 1: single fetch read
    f_req = 1; f_addr = 8'h10;
    tick();
    check("t1_no_gnt_first_edge", 32'(gnt), 32'h0);
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_csel", 32'(ram_csel), 32'h1);
    check("t1_read", 32'(ram_read), 32'h1);
    check("t1_addr", 32'(ram_addr), 32'h10);
    f_req = 0;
    tick();
    check("t1_rvalid", 32'(rvalid), 32'h1);
    check("t1_rdata", 32'(rdata), 32'hA5);
    check("t1_gnt_off", 32'(gnt), 32'h0);

    // 2: simultaneous D write and F read, D wins first
    d_req = 1; d_we = 1; d_addr = 8'h80; d_wdata = 8'h3C;
    f_req = 1; f_addr = 8'h00;
    tick();
    check("t2_gnt_d", 32'(gnt), 32'h2);
    check("t2_read_d", 32'(ram_read), 32'h0);
    check("t2_wdata_d", 32'(ram_wdata), 32'h3C);
    check("t2_addr_d", 32'(ram_addr), 32'h80);
    d_req = 0; d_we = 0;
    tick();
    check("t2_gnt_f", 32'(gnt), 32'h1);
    check("t2_wdata_f", 32'(ram_wdata), 32'h0);
    check("t2_no_rvalid_d", 32'(rvalid), 32'h0);
    check("t2_mem_written", 32'(mem[8'h80]), 32'h3C);
    f_req = 0;
    tick();
    check("t2_rvalid_f", 32'(rvalid), 32'h1);
    check("t2_rdata_f", 32'(rdata), 32'h11);
    check("t2_idle_csel", 32'(ram_csel), 32'h0);
    check("t2_idle_read", 32'(ram_read), 32'h1);
    check("t2_idle_addr_hold", 32'(ram_addr), 32'h00);
    tick();
    check("t2_rdata_hold", 32'(rdata), 32'h11);
    check("t2_rvalid_off", 32'(rvalid), 32'h0);

    // 3: X under continuous D and F load
    d_req = 1; d_we = 0; d_addr = 8'h01;
    f_req = 1; f_addr = 8'h02;
    x_req = 1; x_we = 0; x_addr = 8'h55;
    got = 0; waited = 99;
    for (int i = 1; i <= 10 && !got; i++) begin
      tick();
      if (gnt[2]) begin
        got = 1;
        waited = i;
      end
    end
    check("t3_x_granted", 32'(got), 32'h1);
    check("t3_x_wait_bound", 32'(waited <= 6), 32'h1);
    check("t3_x_addr", 32'(ram_addr), 32'h55);
    check("t3_x_age_clear", 32'(dut.age_q[2]), 32'h0);
    d_req = 0; f_req = 0; x_req = 0;
    tick();
    check("t3_x_rvalid", 32'(rvalid), 32'h4);
    check("t3_x_rdata", 32'(rdata), 32'h9C);
    tick();

    // 4: back-to-back reads, rvalid overlaps next grant
    f_req = 1; f_addr = 8'h01;
    tick();
    check("t4_gnt_f", 32'(gnt), 32'h1);
    f_req = 0;
    d_req = 1; d_we = 0; d_addr = 8'h02;
    tick();
    check("t4_gnt_d", 32'(gnt), 32'h2);
    check("t4_rvalid_f", 32'(rvalid), 32'h1);
    check("t4_rdata_f", 32'(rdata), 32'h22);
    d_req = 0;
    tick();
    check("t4_rvalid_d", 32'(rvalid), 32'h2);
    check("t4_rdata_d", 32'(rdata), 32'h33);
    check("t4_gnt_idle", 32'(gnt), 32'h0);

    // 5: reset during an outstanding read
    f_req = 1; f_addr = 8'h10;
    tick();
    check("t5_gnt_f", 32'(gnt), 32'h1);
    f_req = 0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    tick();
    check("t5_rvalid_in_rst", 32'(rvalid), 32'h0);
    rst_n = 1'b1;
    f_req = 1; f_addr = 8'h10;
    tick();
    check("t5_rvalid_after", 32'(rvalid), 32'h0);
    check("t5_no_gnt_first_edge", 32'(gnt), 32'h0);
    tick();
    check("t5_gnt_fresh", 32'(gnt), 32'h1);
    check("t5_rvalid_still_off", 32'(rvalid), 32'h0);
    f_req = 0;
    tick();
    check("t5_rvalid_fresh", 32'(rvalid), 32'h1);
    check("t5_rdata_fresh", 32'(rdata), 32'hA5);

    // 6: X write then D read of the same location
    x_req = 1; x_we = 1; x_addr = 8'h40; x_wdata = 8'h77;
    tick();
    check("t6_gnt_x", 32'(gnt), 32'h4);
    check("t6_read_x", 32'(ram_read), 32'h0);
    check("t6_wdata_x", 32'(ram_wdata), 32'h77);
    x_req = 0; x_we = 0;
    tick();
    check("t6_no_rvalid_x", 32'(rvalid), 32'h0);
    d_req = 1; d_we = 0; d_addr = 8'h40;
    tick();
    check("t6_gnt_d", 32'(gnt), 32'h2);
    d_req = 0;
    tick();
    check("t6_rvalid_d", 32'(rvalid), 32'h2);
    check("t6_rdata_d", 32'(rdata), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
